rs_5_3_cw_checker: RTL and testbench

- Receive-side companion to the RS(5,3) GF(256) encoder.
- Accepts 5-symbol codewords on the codec's output framing: active-low valid, c4 first, c0 last.
- Accumulates both syndromes on the fly and flags each codeword good or bad.
- Buffers the 3 message symbols (c4, c3, c2) in a 2-slot ping-pong buffer and drains them to a downstream consumer under a ready handshake.

---
 rtl/rs_5_3_cw_checker.sv | 214 +++++++++++++++++++++
 tb/tb_rs_5_3_cw_checker.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_5_3_cw_checker.sv
`default_nettype none
// ============================================================================
// rs_5_3_cw_checker : RS(5,3) GF(256) receive checker with ping-pong drain.
// Optional macro RS_SYND_OUT_EN adds SYND1_OUT / SYND2_OUT.   Rev 1.0
// ============================================================================
module rs_5_3_cw_checker #(
   parameter int DROP_BAD = 0,
   parameter int GAP_MAX  = 15
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       DATA_VALID_IN,
   input  logic [7:0] DATA_IN,
   input  logic       READY_IN,
   output logic       MSG_VALID_OUT,
   output logic [7:0] MSG_OUT,
   output logic       CW_DONE,
   output logic       CW_OK,
   output logic       ABORT,
   output logic       OVERFLOW
`ifdef RS_SYND_OUT_EN
   ,
   output logic [7:0] SYND1_OUT,
   output logic [7:0] SYND2_OUT
`endif
);

   // beta = alpha^51 in GF(2^8) mod 0x11D
   localparam logic [7:0] BETA     = 8'h0A;
   localparam logic [7:0] POLY_LOW = 8'h1D;
   localparam int         GW       = (GAP_MAX < 2) ? 1 : $clog2(GAP_MAX + 1);
   localparam logic [GW-1:0] GAP_LAST = GW'((GAP_MAX > 0) ? (GAP_MAX - 1) : 0);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_SEND = 1'b1;

   // Shift-and-add against a constant operand folds into a fixed XOR network.
   function automatic logic [7:0] mul_beta(input logic [7:0] a);
      logic [7:0] acc;
      logic [7:0] sh;
      acc = 8'h00;
      sh  = a;
      for (int i = 0; i < 8; i++) begin
         if (BETA[i]) acc = acc ^ sh;
         sh = {sh[6:0], 1'b0} ^ (sh[7] ? POLY_LOW : 8'h00);
      end
      return acc;
   endfunction

   logic [2:0]    sym_cnt;
   logic [GW-1:0] gap_cnt;
   logic [7:0]    s1_acc;
   logic [7:0]    s2_acc;
   logic          discard;
   logic [7:0]    slot_mem [2][3];
   logic [1:0]    slot_full;
   logic          wr_ptr;
   logic          rd_ptr;
   logic [0:0]    state;
   logic [1:0]    idx;

   logic       beat;
   logic       first_beat;
   logic       last_beat;
   logic       drop_now;
   logic [7:0] s1_fin;
   logic [7:0] s2_fin;
   logic       syn_ok;
   logic       do_commit;
   logic       gap_expire;
   logic       xfer_last;

   assign beat       = ~DATA_VALID_IN;
   assign first_beat = beat && (sym_cnt == 3'd0);
   assign last_beat  = beat && (sym_cnt == 3'd4);
   // Overflow decision is latched at beat 0; later frees do not rescue the codeword.
   assign drop_now   = first_beat ? (&slot_full) : discard;
   assign s1_fin     = s1_acc ^ DATA_IN;
   assign s2_fin     = mul_beta(s2_acc) ^ DATA_IN;
   assign syn_ok     = (s1_fin == 8'h00) && (s2_fin == 8'h00);
   assign do_commit  = last_beat && !discard && (syn_ok || (DROP_BAD == 0));
   assign gap_expire = (GAP_MAX != 0) && !beat && (sym_cnt != 3'd0) && (gap_cnt == GAP_LAST);
   assign xfer_last  = (state == ST_SEND) && READY_IN && (idx == 2'd2);

   assign MSG_VALID_OUT = (state != ST_SEND);

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         sym_cnt  <= 3'd0;
         gap_cnt  <= '0;
         s1_acc   <= 8'h00;
         s2_acc   <= 8'h00;
         discard  <= 1'b0;
         OVERFLOW <= 1'b0;
      end else if (beat) begin
         gap_cnt <= '0;
         if (first_beat) begin
            s1_acc  <= DATA_IN;
            s2_acc  <= DATA_IN;
            discard <= &slot_full;
            if (&slot_full) OVERFLOW <= 1'b1;
         end else begin
            s1_acc <= s1_fin;
            s2_acc <= s2_fin;
         end
         if (last_beat) begin
            sym_cnt <= 3'd0;
            s1_acc  <= 8'h00;
            s2_acc  <= 8'h00;
            discard <= 1'b0;
         end else begin
            sym_cnt <= sym_cnt + 3'd1;
         end
      end else if (gap_expire) begin
         sym_cnt <= 3'd0;
         gap_cnt <= '0;
         s1_acc  <= 8'h00;
         s2_acc  <= 8'h00;
         discard <= 1'b0;
      end else if ((sym_cnt != 3'd0) && (GAP_MAX != 0)) begin
         gap_cnt <= gap_cnt + GW'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         CW_DONE <= 1'b0;
         CW_OK   <= 1'b0;
         ABORT   <= 1'b0;
      end else begin
         CW_DONE <= last_beat;
         CW_OK   <= last_beat && syn_ok;
         ABORT   <= gap_expire;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         for (int s = 0; s < 2; s++) begin
            for (int b = 0; b < 3; b++) begin
               slot_mem[s][b] <= 8'h00;
            end
         end
      end else if (beat && (sym_cnt < 3'd3) && !drop_now) begin
         slot_mem[wr_ptr][sym_cnt[1:0]] <= DATA_IN;
      end
   end

   // Commit and free always target different slots, so both may land on one edge.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         slot_full <= 2'b00;
         wr_ptr    <= 1'b0;
         rd_ptr    <= 1'b0;
      end else begin
         if (do_commit) begin
            slot_full[wr_ptr] <= 1'b1;
            wr_ptr            <= ~wr_ptr;
         end
         if (xfer_last) begin
            slot_full[rd_ptr] <= 1'b0;
            rd_ptr            <= ~rd_ptr;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state   <= ST_IDLE;
         idx     <= 2'd0;
         MSG_OUT <= 8'h00;
      end else begin
         case (state)
            ST_IDLE: begin
               if (slot_full[rd_ptr]) begin
                  state   <= ST_SEND;
                  idx     <= 2'd0;
                  MSG_OUT <= slot_mem[rd_ptr][0];
               end
            end
            ST_SEND: begin
               if (READY_IN) begin
                  if (idx == 2'd2) begin
                     if (slot_full[~rd_ptr]) begin
                        idx     <= 2'd0;
                        MSG_OUT <= slot_mem[~rd_ptr][0];
                     end else begin
                        state <= ST_IDLE;
                     end
                  end else begin
                     idx     <= idx + 2'd1;
                     MSG_OUT <= slot_mem[rd_ptr][idx + 2'd1];
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef RS_SYND_OUT_EN
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         SYND1_OUT <= 8'h00;
         SYND2_OUT <= 8'h00;
      end else if (last_beat) begin
         SYND1_OUT <= s1_fin;
         SYND2_OUT <= s2_fin;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rs_5_3_cw_checker.sv
`default_nettype none
// Testbench for rs_5_3_cw_checker: two instances (DROP_BAD 0 and 1) against a
// queue-based reference model, directed scenarios followed by random traffic.
module tb_rs_5_3_cw_checker;

   localparam int GAP_MAX = 15;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       dvalid_n;
   logic [7:0] din;
   logic       ready;

   logic [1:0] mvalid_n;
   logic [7:0] mout [2];
   logic [1:0] cw_done;
   logic [1:0] cw_ok;
   logic [1:0] abort_p;
   logic [1:0] ovf;
`ifdef RS_SYND_OUT_EN
   logic [7:0] synd1 [2];
   logic [7:0] synd2 [2];
`endif

   always #5 clk = ~clk;

   rs_5_3_cw_checker #(.DROP_BAD(0), .GAP_MAX(GAP_MAX)) u_dut_keep (
      .CLK(clk), .RESET(rst_n), .DATA_VALID_IN(dvalid_n), .DATA_IN(din),
      .READY_IN(ready), .MSG_VALID_OUT(mvalid_n[0]), .MSG_OUT(mout[0]),
      .CW_DONE(cw_done[0]), .CW_OK(cw_ok[0]), .ABORT(abort_p[0]), .OVERFLOW(ovf[0])
`ifdef RS_SYND_OUT_EN
      , .SYND1_OUT(synd1[0]), .SYND2_OUT(synd2[0])
`endif
   );

   rs_5_3_cw_checker #(.DROP_BAD(1), .GAP_MAX(GAP_MAX)) u_dut_drop (
      .CLK(clk), .RESET(rst_n), .DATA_VALID_IN(dvalid_n), .DATA_IN(din),
      .READY_IN(ready), .MSG_VALID_OUT(mvalid_n[1]), .MSG_OUT(mout[1]),
      .CW_DONE(cw_done[1]), .CW_OK(cw_ok[1]), .ABORT(abort_p[1]), .OVERFLOW(ovf[1])
`ifdef RS_SYND_OUT_EN
      , .SYND1_OUT(synd1[1]), .SYND2_OUT(synd2[1])
`endif
   );

   int n_checks = 0;
   int n_errors = 0;
   int rdy_mode;
   logic [7:0] beta_v;

   // Reference model state
   logic [7:0]  cur [5];
   int          ccnt;
   int          gap;
   logic        exp_done, exp_ok, exp_abort;
   logic [7:0]  exp_s1, exp_s2;
   logic        disc  [2];
   logic [23:0] fifo  [2][2];
   int          fcnt  [2];
   logic        snd   [2];
   int          sidx  [2];
   logic        e_vn  [2];
   logic [7:0]  e_msg [2];
   logic        e_ovf [2];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = 16'h0000;
      for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
      for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011D << (i - 8));
      return p[7:0];
   endfunction

   function automatic logic [7:0] gf_pow(input logic [7:0] a, input int e);
      logic [7:0] r;
      r = 8'h01;
      for (int i = 0; i < e; i++) r = gf_mul(r, a);
      return r;
   endfunction

   // Systematic encoder: solve S1 = S2 = 0 for the two parity symbols by search.
   function automatic logic [39:0] encode(input logic [23:0] m);
      logic [7:0] s, t, c0, c1;
      s  = m[23:16] ^ m[15:8] ^ m[7:0];
      t  = gf_mul(m[23:16], gf_pow(beta_v, 4)) ^ gf_mul(m[15:8], gf_pow(beta_v, 3))
         ^ gf_mul(m[7:0], gf_pow(beta_v, 2));
      c1 = 8'h00;
      for (int v = 0; v < 256; v++) begin
         if ((gf_mul(8'(v), beta_v) ^ 8'(v)) == (s ^ t)) c1 = 8'(v);
      end
      c0 = c1 ^ s;
      return {m, c1, c0};
   endfunction

   function automatic logic [39:0] random_cw(input bit bad);
      logic [39:0] cw;
      logic [39:0] err;
      int pos;
      cw = encode(24'($urandom));
      if (bad) begin
         err = 40'($urandom_range(1, 255));
         pos = $urandom_range(0, 4);
         cw  = cw ^ (err << (8 * pos));
      end
      return cw;
   endfunction

   task automatic model_step();
      int          old_cnt [2];
      logic        done;
      logic [7:0]  s1, s2;
      logic [23:0] newmsg;
      exp_done  = 1'b0;
      exp_ok    = 1'b0;
      exp_abort = 1'b0;
      done      = 1'b0;
      newmsg    = '0;
      if (!rst_n) begin
         ccnt = 0; gap = 0; exp_s1 = 8'h00; exp_s2 = 8'h00;
         for (int k = 0; k < 2; k++) begin
            disc[k] = 1'b0; fcnt[k] = 0; snd[k] = 1'b0; sidx[k] = 0;
            e_vn[k] = 1'b1; e_msg[k] = 8'h00; e_ovf[k] = 1'b0;
         end
         return;
      end
      for (int k = 0; k < 2; k++) old_cnt[k] = fcnt[k];
      if (!dvalid_n) begin
         if (ccnt == 0) begin
            for (int k = 0; k < 2; k++) begin
               disc[k] = (fcnt[k] == 2);
               if (disc[k]) e_ovf[k] = 1'b1;
            end
         end
         cur[ccnt] = din;
         ccnt++;
         gap = 0;
         if (ccnt == 5) begin
            s1 = 8'h00; s2 = 8'h00;
            for (int j = 0; j < 5; j++) begin
               s1 = s1 ^ cur[j];
               s2 = s2 ^ gf_mul(cur[j], gf_pow(beta_v, 4 - j));
            end
            exp_done = 1'b1;
            exp_ok   = (s1 == 8'h00) && (s2 == 8'h00);
            exp_s1   = s1;
            exp_s2   = s2;
            done     = 1'b1;
            newmsg   = {cur[0], cur[1], cur[2]};
            ccnt     = 0;
         end
      end else if (ccnt != 0 && GAP_MAX != 0) begin
         gap++;
         if (gap == GAP_MAX) begin
            exp_abort = 1'b1;
            ccnt = 0;
            gap  = 0;
         end
      end
      for (int k = 0; k < 2; k++) begin
         if (!snd[k]) begin
            if (old_cnt[k] > 0) begin
               snd[k] = 1'b1; sidx[k] = 0; e_vn[k] = 1'b0;
               e_msg[k] = fifo[k][0][23:16];
            end
         end else if (ready) begin
            if (sidx[k] == 2) begin
               fifo[k][0] = fifo[k][1];
               fcnt[k]--;
               if (old_cnt[k] >= 2) begin
                  sidx[k] = 0;
                  e_msg[k] = fifo[k][0][23:16];
               end else begin
                  snd[k] = 1'b0;
                  e_vn[k] = 1'b1;
               end
            end else begin
               sidx[k]++;
               e_msg[k] = fifo[k][0][23 - 8 * sidx[k] -: 8];
            end
         end
         if (done && !disc[k] && (k == 0 || exp_ok)) begin
            fifo[k][fcnt[k]] = newmsg;
            fcnt[k]++;
         end
      end
   endtask

   task automatic compare();
      for (int k = 0; k < 2; k++) begin
         check_eq($sformatf("msg_valid%0d", k), 32'(mvalid_n[k]), 32'(e_vn[k]));
         if (!e_vn[k]) check_eq($sformatf("msg_out%0d", k), 32'(mout[k]), 32'(e_msg[k]));
         check_eq($sformatf("cw_done%0d", k), 32'(cw_done[k]), 32'(exp_done));
         if (exp_done) check_eq($sformatf("cw_ok%0d", k), 32'(cw_ok[k]), 32'(exp_ok));
         check_eq($sformatf("abort%0d", k), 32'(abort_p[k]), 32'(exp_abort));
         check_eq($sformatf("overflow%0d", k), 32'(ovf[k]), 32'(e_ovf[k]));
`ifdef RS_SYND_OUT_EN
         check_eq($sformatf("synd1_%0d", k), 32'(synd1[k]), 32'(exp_s1));
         check_eq($sformatf("synd2_%0d", k), 32'(synd2[k]), 32'(exp_s2));
`endif
      end
   endtask

   task automatic cycle(input logic vn, input logic [7:0] d);
      dvalid_n = vn;
      din      = d;
      case (rdy_mode)
         0:       ready = 1'b0;
         1:       ready = 1'b1;
         default: ready = 1'($urandom_range(0, 1));
      endcase
      model_step();
      @(posedge clk);
      @(negedge clk);
      compare();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b1, 8'($urandom));
   endtask

   task automatic send_cw(input logic [39:0] cw, input int max_gap);
      for (int i = 0; i < 5; i++) begin
         cycle(1'b0, cw[39 - 8 * i -: 8]);
         if (i < 4 && max_gap > 0) idle($urandom_range(0, max_gap));
      end
   endtask

   task automatic send_partial(input int nbeats, input int idles);
      for (int i = 0; i < nbeats; i++) cycle(1'b0, 8'($urandom));
      idle(idles);
   endtask

   task automatic reset_pulse(input logic vn);
      rst_n = 1'b0;
      cycle(vn, 8'($urandom));
      rst_n = 1'b1;
   endtask

   initial begin
      logic [39:0] cw;
      int r;
      rst_n = 1'b0; dvalid_n = 1'b1; din = 8'h00; ready = 1'b0; rdy_mode = 0;
      beta_v = gf_pow(8'h02, 51);
      cycle(1'b1, 8'h00);
      cycle(1'b1, 8'h00);
      rst_n = 1'b1;
      idle(2);

      // all-zero codeword, then the 0x50 message, then a corrupted copy
      rdy_mode = 1;
      send_cw(40'h0, 0);
      idle(6);
      cw = encode(24'h500000);
      send_cw(cw, 0);
      idle(6);
      send_cw(cw ^ 40'h05, 0);
      idle(6);

      // stalled consumer: two buffered, third overflows, then a gapless drain
      rdy_mode = 0;
      send_cw(random_cw(1'b0), 0);
      send_cw(random_cw(1'b0), 0);
      send_cw(random_cw(1'b0), 0);
      idle(2);
      check_eq("overflow_sticky", 32'(ovf[0]), 32'd1);
      rdy_mode = 1;
      idle(10);

      // gap timeout boundary: GAP_MAX-1 idles survive, GAP_MAX idles abort
      send_cw(random_cw(1'b0), GAP_MAX - 1);
      idle(4);
      send_partial(3, GAP_MAX + 1);
      send_cw(random_cw(1'b0), 0);
      idle(6);
      cycle(1'b0, 8'h11);
      idle(GAP_MAX - 1);
      send_partial(4, 2);
      idle(GAP_MAX);

      // reset during beat 2 and while the drain is stalled
      reset_pulse(1'b1);
      send_partial(2, 0);
      reset_pulse(1'b0);
      idle(2);
      rdy_mode = 0;
      send_cw(40'h0, 0);
      idle(3);
      reset_pulse(1'b1);
      idle(2);
      rdy_mode = 1;
      send_cw(40'h0, 0);
      idle(6);

      // random traffic
      for (int it = 0; it < 300; it++) begin
         if (it % 20 == 0) rdy_mode = ($urandom_range(0, 9) < 2) ? 0 : $urandom_range(1, 2);
         r = $urandom_range(0, 99);
         if (r < 3) reset_pulse(1'($urandom_range(0, 1)));
         else if (r < 9) send_partial($urandom_range(1, 4), GAP_MAX + $urandom_range(0, 2));
         else send_cw(random_cw(r < 35), ($urandom_range(0, 3) == 0) ? 3 : 0);
         idle($urandom_range(0, 2));
      end
      rdy_mode = 1;
      idle(12);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
